burst_read_controller: RTL and testbench

- Read-side engine for the memory blocks built from controlled registers. Accepts a start address and length, then issues sequential reads to a synchronous-read memory port with 1-cycle read latency.
- Returns the words as a valid/ready stream with full backpressure support and one word/cycle sustained throughput.
- Sits between a register-bank or memory array and any consumer (UART TX, checker, DMA).

---
 rtl/mem_rd_pkg.sv | 20 ++
 rtl/rd_skid_fifo.sv | 63 ++++++
 rtl/burst_read_controller.sv | 137 +++++++++++++
 tb/tb_burst_read_controller.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rd_pkg.sv
// Shared types and sizing for the burst read engine.
//   state_t   : controller FSM states
//   BUF_DEPTH : depth of the return-data skid FIFO
//   CNT_W     : width of a FIFO occupancy count (0..BUF_DEPTH)
//   PTR_W     : width of a FIFO read/write pointer
//   OCC_W     : width of buffered + in-flight occupancy arithmetic
package mem_rd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int unsigned BUF_DEPTH = 2;
   localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1);
   localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);
   localparam int unsigned OCC_W     = CNT_W + 1;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO that captures memory read data and presents it as a stream head.
//   clk_in, rst_n_in : clock, async active-low reset
//   push_in, wdata_in: write one word
//   pop_in           : remove head word (ignored when empty)
//   flush_in         : discard all contents (wins over push/pop)
//   rdata_out        : current head word
//   count_out        : number of stored words
module rd_skid_fifo
   import mem_rd_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              push_in,
   input  logic              pop_in,
   input  logic              flush_in,
   input  logic [DATA_W-1:0] wdata_in,
   output logic [DATA_W-1:0] rdata_out,
   output logic [CNT_W-1:0]  count_out
);

   logic [DATA_W-1:0] mem_q [BUF_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              do_pop;
   logic              full;

   assign do_pop    = pop_in && (count_q != '0);
   assign full      = (count_q == CNT_W'(BUF_DEPTH));
   assign rdata_out = mem_q[rd_ptr_q];
   assign count_out = count_q;

   // Storage and pointers; depth is a power of two so pointers wrap naturally.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_in) begin
            mem_q[wr_ptr_q] <= wdata_in;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_q + CNT_W'(push_in) - CNT_W'(do_pop);
      end
   end

   // The controller's issue throttle must make an overflow impossible.
   a_no_overflow : assert property (@(posedge clk_in) disable iff (!rst_n_in)
      !(push_in && !flush_in && !do_pop && full))
      else $error("rd_skid_fifo overflow");

endmodule

// File: rtl/burst_read_controller.sv
// Burst read engine: issues sequential reads to a 1-cycle-latency memory port
// and returns the words as a valid/ready stream with full backpressure.
//   clk_in, rst_n_in          : clock, async active-low reset
//   start_in, addr_in, len_in : burst request (sampled in IDLE only)
//   abort_in                  : synchronous cancel of an active burst
//   mem_re_out, mem_addr_out  : memory read port
//   mem_rdata_in              : read data, valid the cycle after mem_re_out
//   dout_out, valid_out, ready_in, last_out : output stream
//   busy_out, done_out        : burst status and completion pulse
module burst_read_controller
   import mem_rd_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned LEN_W  = 5
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              start_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [LEN_W-1:0]  len_in,
   input  logic              abort_in,
   output logic              mem_re_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   input  logic [DATA_W-1:0] mem_rdata_in,
   output logic [DATA_W-1:0] dout_out,
   output logic              valid_out,
   input  logic              ready_in,
   output logic              last_out,
   output logic              busy_out,
   output logic              done_out
);

   state_t            state_q;
   logic [ADDR_W-1:0] next_addr_q;
   logic [ADDR_W-1:0] last_addr_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  issued_q;
   logic [LEN_W-1:0]  popped_q;
   logic              inflight_q;
   logic              done_q;

   logic [CNT_W-1:0]  buf_count;
   logic [OCC_W-1:0]  occupancy;
   logic              pop;
   logic              issue;
   logic              flush;

   // Words held after this cycle: buffered plus in-flight minus the one leaving.
   assign pop       = valid_out && ready_in;
   assign occupancy = OCC_W'(buf_count) + OCC_W'(inflight_q) - OCC_W'(pop);
   assign issue     = (state_q == READ) && (issued_q < len_q)
                      && (occupancy < OCC_W'(BUF_DEPTH));
   assign flush     = abort_in && (state_q != IDLE);

   // Address port shows the word being issued, otherwise the last one issued.
   assign mem_re_out   = issue;
   assign mem_addr_out = issue ? next_addr_q : last_addr_q;

   assign valid_out = (buf_count != '0);
   assign last_out  = valid_out && (popped_q == len_q - LEN_W'(1));
   assign busy_out  = (state_q != IDLE);
   assign done_out  = done_q;

   rd_skid_fifo #(
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .push_in   (inflight_q),
      .pop_in    (pop),
      .flush_in  (flush),
      .wdata_in  (mem_rdata_in),
      .rdata_out (dout_out),
      .count_out (buf_count)
   );

   // Burst FSM, counters and in-flight tracking.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= IDLE;
         next_addr_q <= '0;
         last_addr_q <= '0;
         len_q       <= '0;
         issued_q    <= '0;
         popped_q    <= '0;
         inflight_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         inflight_q <= issue;
         if (issue) begin
            next_addr_q <= next_addr_q + ADDR_W'(1);
            last_addr_q <= next_addr_q;
            issued_q    <= issued_q + LEN_W'(1);
         end
         if (pop) begin
            popped_q <= popped_q + LEN_W'(1);
         end

         case (state_q)
            IDLE: begin
               if (start_in && !abort_in) begin
                  if (len_in == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q     <= READ;
                     len_q       <= len_in;
                     next_addr_q <= addr_in;
                     issued_q    <= '0;
                     popped_q    <= '0;
                  end
               end
            end
            READ: begin
               if (abort_in) begin
                  state_q    <= IDLE;
                  inflight_q <= 1'b0;
               end else if (issue && (issued_q + LEN_W'(1) == len_q)) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (abort_in) begin
                  state_q    <= IDLE;
                  inflight_q <= 1'b0;
               end else if (occupancy == '0) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_burst_read_controller.sv
// Self-checking bench for burst_read_controller: directed vector table,
// hand-written abort/reset sequences and randomized bursts scored against a
// queue-based model of the expected address and data streams.
module tb_burst_read_controller;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned LEN_W  = 5;
   localparam int          NWORDS = 16;
   localparam int          BUDGET = 200;

   logic              clk_in = 1'b0;
   logic              rst_n_in;
   logic              start_in;
   logic [ADDR_W-1:0] addr_in;
   logic [LEN_W-1:0]  len_in;
   logic              abort_in;
   logic              mem_re_out;
   logic [ADDR_W-1:0] mem_addr_out;
   logic [DATA_W-1:0] mem_rdata_in;
   logic [DATA_W-1:0] dout_out;
   logic              valid_out;
   logic              ready_in;
   logic              last_out;
   logic              busy_out;
   logic              done_out;

   logic [DATA_W-1:0] tb_mem [NWORDS];

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   burst_read_controller #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) dut (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .start_in     (start_in),
      .addr_in      (addr_in),
      .len_in       (len_in),
      .abort_in     (abort_in),
      .mem_re_out   (mem_re_out),
      .mem_addr_out (mem_addr_out),
      .mem_rdata_in (mem_rdata_in),
      .dout_out     (dout_out),
      .valid_out    (valid_out),
      .ready_in     (ready_in),
      .last_out     (last_out),
      .busy_out     (busy_out),
      .done_out     (done_out)
   );

   // Synchronous-read memory with one cycle of latency.
   always @(posedge clk_in) begin
      if (mem_re_out) mem_rdata_in <= tb_mem[mem_addr_out];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Run one burst; the expected streams come from address arithmetic on tb_mem.
   // rmode: 0 ready always high, 1 ready 1,0,0 repeating, 2 random ready.
   // exp_first / exp_done: cycle index (0 = first cycle after start edge), -1 = don't care.
   task automatic run_burst(input int a, input int l, input int rmode,
                            input int exp_first, input int exp_done);
      logic [DATA_W-1:0] exp_q[$];
      int                addr_q[$];
      int                issued, popped, first_valid, first_re, done_idx, outst;
      logic              prev_stall;
      logic [DATA_W-1:0] prev_dout;
      for (int i = 0; i < l; i++) begin
         addr_q.push_back((a + i) % NWORDS);
         exp_q.push_back(tb_mem[(a + i) % NWORDS]);
      end
      @(negedge clk_in);
      start_in = 1'b1;
      addr_in  = ADDR_W'(a);
      len_in   = LEN_W'(l);
      @(negedge clk_in);
      start_in    = 1'b0;
      issued      = 0;
      popped      = 0;
      first_valid = -1;
      first_re    = -1;
      done_idx    = -1;
      prev_stall  = 1'b0;
      prev_dout   = '0;
      for (int cyc = 0; cyc < BUDGET; cyc++) begin
         case (rmode)
            0:       ready_in = 1'b1;
            1:       ready_in = ((cyc % 3) == 0);
            default: ready_in = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (mem_re_out) begin
            if (first_re < 0) first_re = cyc;
            if (addr_q.size() == 0) check("extra_issue", 1, 0);
            else check("mem_addr", 32'(mem_addr_out), addr_q.pop_front());
         end
         outst = issued - popped - int'(valid_out && ready_in) + int'(mem_re_out);
         check("outstanding_le2", 32'(outst <= 2), 1);
         if (mem_re_out) issued++;
         if (prev_stall) begin
            check("stall_valid", 32'(valid_out), 1);
            check("stall_dout", 32'(dout_out), 32'(prev_dout));
         end
         if (valid_out && first_valid < 0) first_valid = cyc;
         if (valid_out && ready_in) begin
            if (exp_q.size() == 0) check("extra_word", 1, 0);
            else begin
               check("last", 32'(last_out), 32'(exp_q.size() == 1));
               check("dout", 32'(dout_out), 32'(exp_q.pop_front()));
            end
            popped++;
         end
         prev_stall = valid_out && !ready_in;
         prev_dout  = dout_out;
         if (done_out) begin
            done_idx = cyc;
            check("busy_at_done", 32'(busy_out), 0);
            break;
         end
         check("busy_during", 32'(busy_out), 1);
         @(negedge clk_in);
      end
      if (done_idx < 0) check("done_timeout", 0, 1);
      check("words_left", 32'(exp_q.size()), 0);
      check("issues_left", 32'(addr_q.size()), 0);
      if (l > 0) begin
         check("first_issue_idx", 32'(first_re), 0);
         check("addr_hold", 32'(mem_addr_out), 32'((a + l - 1) % NWORDS));
      end
      if (exp_first >= 0) check("first_valid_idx", 32'(first_valid), 32'(exp_first));
      if (exp_done >= 0)  check("done_idx", 32'(done_idx), 32'(exp_done));
      @(negedge clk_in);
      #1;
      check("done_one_pulse", 32'(done_out), 0);
      check("idle_busy", 32'(busy_out), 0);
   endtask

   typedef struct {
      int addr;
      int len;
      int rmode;
      int exp_first;
      int exp_done;
   } vec_t;

   vec_t vecs [7];

   initial begin
      // With ready held high, word k of a burst transfers in cycle k+2 and
      // done follows the final transfer by one cycle.
      vecs[0] = '{addr: 2,  len: 4,  rmode: 0, exp_first: 2,  exp_done: 6};
      vecs[1] = '{addr: 14, len: 4,  rmode: 0, exp_first: 2,  exp_done: 6};
      vecs[2] = '{addr: 0,  len: 0,  rmode: 0, exp_first: -1, exp_done: 0};
      vecs[3] = '{addr: 5,  len: 1,  rmode: 0, exp_first: 2,  exp_done: 3};
      vecs[4] = '{addr: 0,  len: 16, rmode: 0, exp_first: 2,  exp_done: 18};
      vecs[5] = '{addr: 3,  len: 20, rmode: 0, exp_first: 2,  exp_done: 22};
      vecs[6] = '{addr: 2,  len: 4,  rmode: 1, exp_first: 2,  exp_done: -1};

      for (int i = 0; i < NWORDS; i++) tb_mem[i] = 8'hA0 + 8'(i);
      rst_n_in     = 1'b0;
      start_in     = 1'b0;
      addr_in      = '0;
      len_in       = '0;
      abort_in     = 1'b0;
      ready_in     = 1'b0;
      mem_rdata_in = '0;

      #1;
      check("rst_re", 32'(mem_re_out), 0);
      check("rst_addr", 32'(mem_addr_out), 0);
      check("rst_dout", 32'(dout_out), 0);
      check("rst_valid", 32'(valid_out), 0);
      check("rst_last", 32'(last_out), 0);
      check("rst_busy", 32'(busy_out), 0);
      check("rst_done", 32'(done_out), 0);
      #11 rst_n_in = 1'b1;

      foreach (vecs[i]) run_burst(vecs[i].addr, vecs[i].len, vecs[i].rmode,
                                  vecs[i].exp_first, vecs[i].exp_done);

      // Abort a len=8 burst after two words have been transferred.
      @(negedge clk_in);
      start_in = 1'b1; addr_in = 4'd0; len_in = 5'd8; ready_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         #1;
         if (cyc == 2) check("abort_w0", 32'(dout_out), 32'(tb_mem[0]));
         if (cyc == 3) check("abort_w1", 32'(dout_out), 32'(tb_mem[1]));
         @(negedge clk_in);
      end
      ready_in = 1'b0; abort_in = 1'b1;
      #1;
      check("pre_abort_busy", 32'(busy_out), 1);
      check("pre_abort_valid", 32'(valid_out), 1);
      @(negedge clk_in);
      abort_in = 1'b0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         #1;
         check("abort_valid", 32'(valid_out), 0);
         check("abort_busy", 32'(busy_out), 0);
         check("abort_done", 32'(done_out), 0);
         check("abort_re", 32'(mem_re_out), 0);
         @(negedge clk_in);
      end
      run_burst(6, 3, 0, 2, 5);

      // Start and abort together in IDLE: abort wins.
      @(negedge clk_in);
      start_in = 1'b1; abort_in = 1'b1; addr_in = 4'd1; len_in = 5'd4;
      @(negedge clk_in);
      start_in = 1'b0; abort_in = 1'b0;
      #1;
      check("sa_busy", 32'(busy_out), 0);
      check("sa_re", 32'(mem_re_out), 0);
      check("sa_done", 32'(done_out), 0);

      // Asynchronous reset mid-burst with the FIFO full.
      @(negedge clk_in);
      start_in = 1'b1; addr_in = 4'd3; len_in = 5'd8; ready_in = 1'b0;
      @(negedge clk_in);
      start_in = 1'b0;
      repeat (3) @(negedge clk_in);
      #1;
      check("pre_rst_valid", 32'(valid_out), 1);
      #2 rst_n_in = 1'b0;
      #1;
      check("mrst_re", 32'(mem_re_out), 0);
      check("mrst_addr", 32'(mem_addr_out), 0);
      check("mrst_dout", 32'(dout_out), 0);
      check("mrst_valid", 32'(valid_out), 0);
      check("mrst_last", 32'(last_out), 0);
      check("mrst_busy", 32'(busy_out), 0);
      check("mrst_done", 32'(done_out), 0);
      repeat (3) @(negedge clk_in);
      #2 rst_n_in = 1'b1;
      run_burst(14, 4, 0, 2, 6);

      // Randomized bursts with random memory contents and random backpressure.
      for (int n = 0; n < 20; n++) begin
         int a, l;
         for (int i = 0; i < NWORDS; i++) tb_mem[i] = 8'($urandom);
         a = int'($urandom_range(0, NWORDS - 1));
         l = int'($urandom_range(0, 31));
         run_burst(a, l, 2, (l > 0) ? 2 : -1, (l == 0) ? 0 : -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
